udt_tx_arbiter: RTL

- Packet-level arbiter sharing the single 64-bit UDT transmit AXI-stream between six control-packet generators and the data-packet sender.
- Control packets have fixed priority over data. A burst limiter guarantees data is not starved.
- Checks the UDT type field on the first beat of every granted packet.
- Sits between the packet generators and the transmit framing/encode stage; the mirror of the receive-side decode split.

---
 rtl/udt_tx_arbiter_if.sv | 44 ++++
 rtl/udt_tx_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/udt_tx_arbiter_if.sv
// Bundles the UDT transmit arbiter's stream signals.
// Ports (signals):
//   ctrl_tvalid/ctrl_tdata/ctrl_tlast/ctrl_tready - six control-packet sources
//   data_tvalid/data_tdata/data_tlast/data_tready - data-packet source
//   out_tvalid/out_tdata/out_tlast/out_tready     - merged transmit stream
//   grant_id, type_err                            - arbitration status
// Modports: master = the arbiter (drives the merged stream and source readies),
//           slave  = its surroundings (generators, downstream sink, monitor).
interface udt_tx_arbiter_if;
    logic [5:0]   ctrl_tvalid;
    logic [383:0] ctrl_tdata;
    logic [5:0]   ctrl_tlast;
    logic [5:0]   ctrl_tready;
    logic         data_tvalid;
    logic [63:0]  data_tdata;
    logic         data_tlast;
    logic         data_tready;
    logic         out_tvalid;
    logic [63:0]  out_tdata;
    logic         out_tlast;
    logic         out_tready;
    logic [2:0]   grant_id;
    logic         type_err;

    modport master (
        input  ctrl_tvalid, ctrl_tdata, ctrl_tlast,
        output ctrl_tready,
        input  data_tvalid, data_tdata, data_tlast,
        output data_tready,
        output out_tvalid, out_tdata, out_tlast,
        input  out_tready,
        output grant_id, type_err
    );

    modport slave (
        output ctrl_tvalid, ctrl_tdata, ctrl_tlast,
        input  ctrl_tready,
        output data_tvalid, data_tdata, data_tlast,
        input  data_tready,
        input  out_tvalid, out_tdata, out_tlast,
        output out_tready,
        input  grant_id, type_err
    );
endinterface

// File: rtl/udt_tx_arbiter.sv
// Packet-level arbiter merging six UDT control-packet generators and the
// data-packet sender onto one 64-bit transmit stream. Control has fixed
// priority (lowest index first); a burst limiter forces a data grant after
// MAX_CTRL_BURST consecutive control grants made while data was waiting.
// The first beat of every granted packet has its UDT type field checked;
// a mismatch sets the sticky type_err flag but the packet is forwarded as-is.
// Ports:
//   clk      - core clock
//   core_rst - asynchronous active-high reset
//   bus      - udt_tx_arbiter_if.master (source streams, merged stream, status)
module udt_tx_arbiter #(
    parameter int unsigned MAX_CTRL_BURST = 4,
    parameter int unsigned CNT_W          = 4
) (
    input  logic              clk,
    input  logic              core_rst,
    udt_tx_arbiter_if.master  bus
);

    localparam int unsigned NUM_CTRL = 6;
    localparam int unsigned DATA_W   = 64;
    localparam logic [2:0]  GNT_DATA = 3'd6;
    localparam logic [2:0]  GNT_NONE = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state;
    logic [2:0]         grant_id;
    logic [CNT_W-1:0]   burst_cnt;
    logic               first_beat;
    logic               type_err;

    logic               sel_valid;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic [5:0]         ctrl_ready;
    logic               data_ready;

    logic               any_ctrl;
    logic [2:0]         ctrl_idx;
    logic [2:0]         win_id;
    logic               burst_full;
    logic               xfer;
    logic               type_bad;

    // Expected UDT type field for each control source.
    function automatic logic [15:0] ctrl_type(input logic [2:0] id);
        case (id)
            3'd0:    ctrl_type = 16'h8005;
            3'd1:    ctrl_type = 16'h8000;
            3'd2:    ctrl_type = 16'h8006;
            3'd3:    ctrl_type = 16'h8002;
            3'd4:    ctrl_type = 16'h8003;
            3'd5:    ctrl_type = 16'h8001;
            default: ctrl_type = 16'h0000;
        endcase
    endfunction

    // Winner selection used while IDLE.
    always_comb begin
        any_ctrl   = |bus.ctrl_tvalid;
        ctrl_idx   = GNT_NONE;
        burst_full = (burst_cnt == CNT_W'(MAX_CTRL_BURST));
        for (int i = NUM_CTRL - 1; i >= 0; i--) begin
            if (bus.ctrl_tvalid[i]) begin
                ctrl_idx = 3'(i);
            end
        end
        if (bus.data_tvalid && burst_full) begin
            win_id = GNT_DATA;
        end else if (any_ctrl) begin
            win_id = ctrl_idx;
        end else if (bus.data_tvalid) begin
            win_id = GNT_DATA;
        end else begin
            win_id = GNT_NONE;
        end
    end

    // Merged-stream mux: in LOCK the granted source is passed straight through.
    always_comb begin
        sel_valid  = 1'b0;
        sel_data   = '0;
        sel_last   = 1'b0;
        ctrl_ready = '0;
        data_ready = 1'b0;
        if (state == LOCK) begin
            if (grant_id == GNT_DATA) begin
                sel_valid  = bus.data_tvalid;
                sel_data   = bus.data_tdata;
                sel_last   = bus.data_tlast;
                data_ready = bus.out_tready;
            end else begin
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (grant_id == 3'(i)) begin
                        sel_valid     = bus.ctrl_tvalid[i];
                        sel_data      = bus.ctrl_tdata[DATA_W*i +: DATA_W];
                        sel_last      = bus.ctrl_tlast[i];
                        ctrl_ready[i] = bus.out_tready;
                    end
                end
            end
        end
    end

    // Data packets must carry a clear control bit; control packets their own type.
    always_comb begin
        xfer = (state == LOCK) && sel_valid && bus.out_tready;
        if (grant_id == GNT_DATA) begin
            type_bad = sel_data[63];
        end else begin
            type_bad = (sel_data[63:48] != ctrl_type(grant_id));
        end
    end

    assign bus.out_tvalid  = sel_valid;
    assign bus.out_tdata   = sel_data;
    assign bus.out_tlast   = sel_last;
    assign bus.ctrl_tready = ctrl_ready;
    assign bus.data_tready = data_ready;
    assign bus.grant_id    = grant_id;
    assign bus.type_err    = type_err;

    // Grant FSM, burst limiter and sticky type-check flag.
    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            state      <= IDLE;
            grant_id   <= GNT_NONE;
            burst_cnt  <= '0;
            first_beat <= 1'b0;
            type_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_id != GNT_NONE) begin
                        state      <= LOCK;
                        grant_id   <= win_id;
                        first_beat <= 1'b1;
                        // Only control grants made while data waits count toward the burst.
                        if (win_id == GNT_DATA || !bus.data_tvalid) begin
                            burst_cnt <= '0;
                        end else if (!burst_full) begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                        end
                    end
                end
                LOCK: begin
                    if (xfer) begin
                        first_beat <= 1'b0;
                        if (first_beat && type_bad) begin
                            type_err <= 1'b1;
                        end
                        if (sel_last) begin
                            state    <= IDLE;
                            grant_id <= GNT_NONE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant_id <= GNT_NONE;
                end
            endcase
        end
    end

endmodule
